mssd_controller: RTL and testbench

MSSD_CONTROLLER -- requirements
Module: mssd_controller

---
 rtl/mssd_controller.sv | 127 ++++++++++++
 tb/tb_mssd_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mssd_controller.sv
// Serial demux frame controller: sequences port, length and payload phases of a frame.
// Optional MSSD_CTRL_ZERO_SKIP_EN adds lenZero so zero-length frames skip the payload phase.
module mssd_controller #(
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   serIn,
  input  logic                   abort,
  input  logic                   onecountCo,
  input  logic                   TwocountCo,
  input  logic                   downcountCo,
`ifdef MSSD_CTRL_ZERO_SKIP_EN
  input  logic                   lenZero,
`endif
  output logic                   onecountEn,
  output logic                   tworegEn,
  output logic                   twocountEn,
  output logic                   fourregEn,
  output logic                   downcountEn,
  output logic                   outEn,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frameCount
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PORT = 3'd1,
    NUM  = 3'd2,
    XMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_next;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The counter advances on the edge that leaves DONE, so it always counts finished frames.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      frameCount <= '0;
    end else if (state == DONE) begin
      frameCount <= frameCount + FRAME_CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!serIn && !abort) begin
          state_next = PORT;
        end
      end
      PORT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (onecountCo) begin
          state_next = NUM;
        end
      end
      NUM: begin
        if (abort) begin
          state_next = IDLE;
        end else if (TwocountCo) begin
`ifdef MSSD_CTRL_ZERO_SKIP_EN
          state_next = lenZero ? DONE : XMIT;
`else
          state_next = XMIT;
`endif
        end
      end
      XMIT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (downcountCo) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore decode: outputs depend only on the registered state.
  always_comb begin
    onecountEn  = 1'b0;
    tworegEn    = 1'b0;
    twocountEn  = 1'b0;
    fourregEn   = 1'b0;
    downcountEn = 1'b0;
    outEn       = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);
    case (state)
      PORT: begin
        onecountEn = 1'b1;
        tworegEn   = 1'b1;
      end
      NUM: begin
        twocountEn = 1'b1;
        fourregEn  = 1'b1;
      end
      XMIT: begin
        downcountEn = 1'b1;
        outEn       = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mssd_controller.sv
// Self-checking bench for mssd_controller (FRAME_CNT_W=2 so the counter wrap is reachable).
// Expected outputs come from a small behavioural model and pass through a scoreboard queue.
module tb_mssd_controller;

  logic       Clk = 1'b0;
  logic       reset;
  logic       serIn;
  logic       abort;
  logic       onecountCo;
  logic       TwocountCo;
  logic       downcountCo;
`ifdef MSSD_CTRL_ZERO_SKIP_EN
  logic       lenZero;
`endif
  logic       onecountEn, tworegEn, twocountEn, fourregEn;
  logic       downcountEn, outEn, busy, done;
  logic [1:0] frameCount;

  typedef struct {
    logic [9:0] val;
    string      tag;
  } exp_t;

  exp_t expQueue[$];
  int   errors = 0;
  int   checks = 0;
  int   modelState = 0;
  int   modelCount = 0;

  mssd_controller #(.FRAME_CNT_W(2)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .serIn       (serIn),
    .abort       (abort),
    .onecountCo  (onecountCo),
    .TwocountCo  (TwocountCo),
    .downcountCo (downcountCo),
`ifdef MSSD_CTRL_ZERO_SKIP_EN
    .lenZero     (lenZero),
`endif
    .onecountEn  (onecountEn),
    .tworegEn    (tworegEn),
    .twocountEn  (twocountEn),
    .fourregEn   (fourregEn),
    .downcountEn (downcountEn),
    .outEn       (outEn),
    .busy        (busy),
    .done        (done),
    .frameCount  (frameCount)
  );

  always #5 Clk = ~Clk;

  // Output vector order: onecountEn,tworegEn,twocountEn,fourregEn,downcountEn,outEn,busy,done
  function automatic logic [7:0] stateOutputs(input int st);
    case (st)
      1:       return 8'b1100_0010;
      2:       return 8'b0011_0010;
      3:       return 8'b0000_1110;
      4:       return 8'b0000_0011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic void pushExpected(input string tag);
    exp_t e;
    e.val = {stateOutputs(modelState), 2'(modelCount)};
    e.tag = tag;
    expQueue.push_back(e);
  endfunction

  task automatic checkOutput();
    exp_t       e;
    logic [9:0] observed;
    observed = {onecountEn, tworegEn, twocountEn, fourregEn, downcountEn, outEn,
                busy, done, frameCount};
    if (expQueue.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_empty observed=%b required=an_entry", observed);
    end else begin
      e = expQueue.pop_front();
      checks++;
      assert (observed === e.val) else begin
        errors++;
        $error("[TB] FAIL %s observed=%b expected=%b", e.tag, observed, e.val);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, check after the rising edge.
  task automatic applyStimulus(input logic s, input logic a, input logic c1, input logic c2,
                               input logic cd, input string tag);
    int nextState;
    @(negedge Clk);
    serIn       = s;
    abort       = a;
    onecountCo  = c1;
    TwocountCo  = c2;
    downcountCo = cd;
    nextState   = modelState;
    case (modelState)
      0: if (!s && !a) nextState = 1;
      1: if (a) nextState = 0; else if (c1) nextState = 2;
      2: begin
        if (a) nextState = 0;
`ifdef MSSD_CTRL_ZERO_SKIP_EN
        else if (c2) nextState = lenZero ? 4 : 3;
`else
        else if (c2) nextState = 3;
`endif
      end
      3: if (a) nextState = 0; else if (cd) nextState = 4;
      default: nextState = 0;
    endcase
    if (modelState == 4) modelCount = (modelCount + 1) % 4;
    modelState = nextState;
    pushExpected(tag);
    @(posedge Clk);
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  // Full frame with stray carries and start bits in the wrong states to show they are ignored.
  task automatic runFrame();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "start");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "port1");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "port2");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "num");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "num4");
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "xmit");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "xmit8");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "done_ignores_start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "after_done");
  endtask

  task automatic enterXmit();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "port1");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "port2");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "num");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "num4");
  endtask

  task automatic asyncReset(input string tag);
    @(negedge Clk);
    #2;
    reset      = 1'b0;
    modelState = 0;
    modelCount = 0;
    #1;
    pushExpected(tag);
    checkOutput();
    @(negedge Clk);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    serIn       = 1'b1;
    abort       = 1'b0;
    onecountCo  = 1'b0;
    TwocountCo  = 1'b0;
    downcountCo = 1'b0;
`ifdef MSSD_CTRL_ZERO_SKIP_EN
    lenZero     = 1'b0;
`endif
    #1;
    pushExpected("reset_state");
    checkOutput();
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b1;

    idleCycles(10);

    runFrame();

    enterXmit();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "xmit1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "xmit2");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "abort_xmit3");
    idleCycles(2);

    enterXmit();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "xmit");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "abort_beats_carry");
    idleCycles(1);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "abort_in_idle");
    idleCycles(1);

    for (int f = 0; f < 4; f++) runFrame();

    enterXmit();
    asyncReset("reset_mid_xmit");
    idleCycles(2);

`ifdef MSSD_CTRL_ZERO_SKIP_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "zs_start");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "zs_port");
    lenZero = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "zs_skip_to_done");
    lenZero = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "zs_after_done");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "zs2_start");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "zs2_port");
    asyncReset("reset_mid_num");
    idleCycles(2);
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "restart");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "restart_port");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
